// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 codes, FSM state type
// and the request legality check used at accept time.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WRITE  = 2'd2
    } state_t;

    // Unsigned variants exist only for loads; halfword/word need natural alignment.
    function automatic logic req_legal(input logic we, input logic [2:0] funct3,
                                       input logic [1:0] addr_lo);
        logic ok;
        case (funct3)
            F3_B:    ok = 1'b1;
            F3_H:    ok = ~addr_lo[0];
            F3_W:    ok = (addr_lo == 2'b00);
            F3_BU:   ok = ~we;
            F3_HU:   ok = ~we & ~addr_lo[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load data extension: selects byte/halfword/word from the low end
// of the RAM read word and sign- or zero-extends it per funct3.
module load_extend
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [2:0]            funct3,
    input  logic [DATA_WIDTH-1:0] word_in,
    output logic [DATA_WIDTH-1:0] word_out
);

    always_comb begin
        word_out = word_in;
        case (funct3)
            F3_B:    word_out = {{(DATA_WIDTH-8){word_in[7]}}, word_in[7:0]};
            F3_BU:   word_out = {{(DATA_WIDTH-8){1'b0}}, word_in[7:0]};
            F3_H:    word_out = {{(DATA_WIDTH-16){word_in[15]}}, word_in[15:0]};
            F3_HU:   word_out = {{(DATA_WIDTH-16){1'b0}}, word_in[15:0]};
            default: word_out = word_in;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit for a byte-addressed data RAM with a
// combinational read port; sub-word stores are done as read-modify-write.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [2:0]               req_funct3,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    output logic                     resp_valid,
    output logic [DATA_WIDTH-1:0]    resp_rdata,
    output logic                     err,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wd,
    input  logic [DATA_WIDTH-1:0]    mem_rd
);

    state_t                   state, state_nxt;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [2:0]               funct3_q;
    logic                     we_q;
    logic [DATA_WIDTH-1:0]    wdata_q;
    logic [DATA_WIDTH-1:0]    old_q;
    logic [DATA_WIDTH-1:0]    load_val;
    logic                     accept;
    logic                     legal;
    logic                     sub_store;

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;
    assign legal     = req_legal(req_we, req_funct3, req_addr[1:0]);
    assign sub_store = we_q && ((funct3_q == F3_B) || (funct3_q == F3_H));
    assign mem_addr  = addr_q;

    load_extend #(.DATA_WIDTH(DATA_WIDTH)) u_load_extend (
        .funct3   (funct3_q),
        .word_in  (mem_rd),
        .word_out (load_val)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        mem_we    = 1'b0;
        mem_wd    = wdata_q;
        case (state)
            IDLE: begin
                if (accept && legal) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                state_nxt = sub_store ? WRITE : IDLE;
                mem_we    = we_q && (funct3_q == F3_W);
            end
            WRITE: begin
                state_nxt = IDLE;
                mem_we    = 1'b1;
                // Merge new low byte/halfword over the word read in ACCESS.
                if (funct3_q == F3_B) begin
                    mem_wd = {old_q[DATA_WIDTH-1:8], wdata_q[7:0]};
                end else begin
                    mem_wd = {old_q[DATA_WIDTH-1:16], wdata_q[15:0]};
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q     <= '0;
            funct3_q   <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            old_q      <= '0;
            resp_valid <= 1'b0;
            err        <= 1'b0;
            resp_rdata <= '0;
        end else begin
            resp_valid <= 1'b0;
            err        <= 1'b0;
            if (accept) begin
                addr_q   <= req_addr;
                funct3_q <= req_funct3;
                we_q     <= req_we;
                wdata_q  <= req_wdata;
                if (!legal) begin
                    resp_valid <= 1'b1;
                    err        <= 1'b1;
                end
            end
            if (state == ACCESS) begin
                if (!we_q) begin
                    resp_rdata <= load_val;
                    resp_valid <= 1'b1;
                end else if (sub_store) begin
                    old_q <= mem_rd;
                end else begin
                    resp_valid <= 1'b1;
                end
            end
            if (state == WRITE) begin
                resp_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: 256-byte wrapping RAM, directed scenarios, then
// random requests checked against a byte-array reference model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        err;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    logic [7:0] ram   [256];
    logic [7:0] model [256];
    logic       poke_en;
    logic [7:0] poke_addr;
    logic [7:0] poke_data;
    logic [7:0] ma0, ma1, ma2, ma3;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_rdata;

    always #5 clk = ~clk;

    load_store_unit #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .err        (err),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wd     (mem_wd),
        .mem_rd     (mem_rd)
    );

    assign ma0    = mem_addr[7:0];
    assign ma1    = ma0 + 8'd1;
    assign ma2    = ma0 + 8'd2;
    assign ma3    = ma0 + 8'd3;
    assign mem_rd = {ram[ma3], ram[ma2], ram[ma1], ram[ma0]};

    always @(posedge clk) begin
        if (mem_we) begin
            ram[ma0] <= mem_wd[7:0];
            ram[ma1] <= mem_wd[15:8];
            ram[ma2] <= mem_wd[23:16];
            ram[ma3] <= mem_wd[31:24];
        end
        if (poke_en) ram[poke_addr] <= poke_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        poke_en   = 1'b1;
        poke_addr = a;
        poke_data = d;
        model[a]  = d;
        @(posedge clk); #1;
        poke_en   = 1'b0;
    endtask

    // One request, from drive to response; expectations come from the byte model.
    task automatic run_req(input string tag, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata);
        int          size;
        logic        legal;
        logic        sgn;
        longint      v;
        logic [31:0] exp_rd;
        int          exp_lat;
        int          exp_we;
        int          lat;
        int          we_cnt;
        int          we_at;
        int          waits;
        logic        got;
        case (f3)
            3'd0, 3'd4: size = 1;
            3'd1, 3'd5: size = 2;
            3'd2:       size = 4;
            default:    size = 0;
        endcase
        sgn   = (f3 < 3'd4);
        legal = (size != 0) && !(we && !sgn) && ((addr % size) == 0);
        exp_rd = last_rdata;
        exp_we = 0;
        if (!legal) begin
            exp_lat = 1;
        end else if (!we) begin
            v = 0;
            for (int i = 0; i < size; i++) v = v + (longint'(model[8'(addr + i)]) << (8 * i));
            if (sgn && v >= (longint'(1) << (8 * size - 1))) v = v - (longint'(1) << (8 * size));
            exp_rd  = v[31:0];
            exp_lat = 2;
        end else begin
            exp_lat = (size == 4) ? 2 : 3;
            exp_we  = 1;
        end

        waits = 0;
        while (!req_ready && waits < 8) begin
            @(posedge clk); #1;
            waits++;
        end
        check({tag, "_ready"}, req_ready, 1'b1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1; we_cnt = 0; we_at = 0; got = 1'b0;
        while (lat <= 6) begin
            if (mem_we) begin
                we_cnt++;
                we_at = lat;
            end
            if (resp_valid) begin
                got = 1'b1;
                break;
            end
            if (!req_ready) begin
                // Junk while busy; must be ignored.
                req_valid  = 1'b1;
                req_we     = 1'($urandom);
                req_funct3 = 3'($urandom);
                req_addr   = $urandom;
                req_wdata  = $urandom;
            end
            @(posedge clk); #1;
            req_valid = 1'b0;
            lat++;
        end
        check({tag, "_resp_seen"}, got, 1'b1);
        if (got) begin
            check({tag, "_latency"}, lat, exp_lat);
            check({tag, "_err"}, err, !legal);
            check({tag, "_rdata"}, resp_rdata, exp_rd);
            check({tag, "_addr"}, mem_addr, addr);
            check({tag, "_we_count"}, we_cnt, exp_we);
            if (exp_we != 0) check({tag, "_we_cycle"}, we_at, exp_lat - 1);
        end
        last_rdata = exp_rd;
        if (legal && we) begin
            for (int i = 0; i < size; i++) model[8'(addr + i)] = 8'(wdata >> (8 * i));
            for (int i = 0; i < 4; i++) check({tag, "_ram"}, ram[8'(addr + i)], model[8'(addr + i)]);
        end
    endtask

    initial begin
        int quiet_bad;
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = '0; req_wdata = '0;
        poke_en = 1'b0; poke_addr = '0; poke_data = '0;
        last_rdata = '0;
        for (int i = 0; i < 256; i++) poke(8'(i), 8'($urandom));
        @(posedge clk); #1;
        rst = 1'b0;

        check("reset_ready", req_ready, 1'b1);
        check("reset_resp_valid", resp_valid, 1'b0);
        check("reset_err", err, 1'b0);
        check("reset_rdata", resp_rdata, 32'h0);
        check("reset_mem_we", mem_we, 1'b0);
        check("reset_mem_addr", mem_addr, 32'h0);

        poke(8'h10, 8'h80); poke(8'h11, 8'h7F); poke(8'h12, 8'h00); poke(8'h13, 8'hFF);
        run_req("lb", 1'b0, 3'b000, 32'h10, 32'h0);
        check("lb_value", resp_rdata, 32'hFFFFFF80);
        run_req("lbu", 1'b0, 3'b100, 32'h10, 32'h0);
        check("lbu_value", resp_rdata, 32'h00000080);

        run_req("sw", 1'b1, 3'b010, 32'h20, 32'hDEADBEEF);
        run_req("lw", 1'b0, 3'b010, 32'h20, 32'h0);
        check("lw_value", resp_rdata, 32'hDEADBEEF);

        poke(8'h40, 8'h44); poke(8'h41, 8'h33); poke(8'h42, 8'h22); poke(8'h43, 8'h11);
        run_req("sb", 1'b1, 3'b000, 32'h40, 32'h000000AA);
        check("sb_word", {ram[8'h43], ram[8'h42], ram[8'h41], ram[8'h40]}, 32'h112233AA);

        run_req("lh_misaligned", 1'b0, 3'b001, 32'h21, 32'h0);
        check("lh_misaligned_state", req_ready, 1'b1);
        run_req("load_f3_011", 1'b0, 3'b011, 32'h20, 32'h0);
        run_req("sbu_illegal", 1'b1, 3'b100, 32'h20, 32'h12345678);

        poke(8'h00, 8'h01); poke(8'h01, 8'h02); poke(8'h02, 8'h03);
        run_req("sb_wrap", 1'b1, 3'b000, 32'hFF, 32'h0000005A);
        check("wrap_b0", ram[8'h00], 8'h01);
        check("wrap_b1", ram[8'h01], 8'h02);
        check("wrap_b2", ram[8'h02], 8'h03);
        check("wrap_bff", ram[8'hFF], 8'h5A);

        // Reset while an SB sits in ACCESS.
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h50; req_wdata = 32'hC3;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("rst_abort_busy", req_ready, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_abort_ready", req_ready, 1'b1);
        check("rst_abort_rdata", resp_rdata, 32'h0);
        quiet_bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (mem_we || resp_valid) quiet_bad++;
            @(posedge clk); #1;
        end
        check("rst_abort_quiet", quiet_bad, 0);
        check("rst_abort_ram", ram[8'h50], model[8'h50]);
        last_rdata = '0;

        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
            run_req("rand", 1'($urandom), 3'($urandom_range(0, 7)), a, $urandom);
        end

        for (int i = 0; i < 256; i++) check("final_ram", ram[i], model[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
